// File: rtl/sprite_rect_draw.sv
// Rectangle sprite plotter: erases the previous rectangle to the background
// colour, then draws the new one, emitting one pixel per clock for a VGA write port.
module sprite_rect_draw #(
    parameter int XW        = 8,
    parameter int YW        = 7,
    parameter int CW        = 3,
    parameter int SPR_W     = 4,
    parameter int SPR_H     = 4,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int BG_COLOUR = 0,
    parameter int ERASE_EN  = 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          go,
    input  logic          erase_only,
    input  logic [XW-1:0] x_in,
    input  logic [YW-1:0] y_in,
    input  logic [CW-1:0] colour_in,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot
);

    localparam int CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int CYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [XW:0]    SW    = (XW+1)'(SCREEN_W);
    localparam logic [YW:0]    SH    = (YW+1)'(SCREEN_H);
    localparam logic [CXW-1:0] CXMAX = CXW'(SPR_W - 1);
    localparam logic [CYW-1:0] CYMAX = CYW'(SPR_H - 1);
    localparam logic [CW-1:0]  BG    = CW'(BG_COLOUR);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t         r_st, w_st_n;
    logic [CXW-1:0] r_cx, w_cx_n;
    logic [CYW-1:0] r_cy, w_cy_n;
    logic [XW-1:0]  r_lx, r_prev_x, r_x;
    logic [YW-1:0]  r_ly, r_prev_y, r_y;
    logic [CW-1:0]  r_lc, r_col;
    logic           r_eo, r_prev_valid;
    logic           r_plot, r_busy, r_done;

    logic           w_accept, w_last, w_on, w_in;
    logic [XW-1:0]  w_ox;
    logic [YW-1:0]  w_oy;
    logic [CW-1:0]  w_col;
    logic [XW:0]    w_sx;
    logic [YW:0]    w_sy;

    // Counters always hold the index of the pixel being presented this cycle,
    // so the next-state values drive the output registers directly.
    always_comb begin
        w_st_n   = r_st;
        w_cx_n   = r_cx;
        w_cy_n   = r_cy;
        w_accept = 1'b0;
        w_last   = (r_cx == CXMAX) && (r_cy == CYMAX);
        case (r_st)
            IDLE, DONE: begin
                w_st_n = IDLE;
                w_cx_n = '0;
                w_cy_n = '0;
                if (go) begin
                    w_accept = 1'b1;
                    if (((ERASE_EN != 0) || erase_only) && r_prev_valid)
                        w_st_n = ERASE;
                    else if (erase_only)
                        w_st_n = DONE;
                    else
                        w_st_n = DRAW;
                end
            end
            ERASE, DRAW: begin
                if (w_last) begin
                    w_cx_n = '0;
                    w_cy_n = '0;
                    w_st_n = (r_st == DRAW || r_eo) ? DONE : DRAW;
                end else if (r_cx == CXMAX) begin
                    w_cx_n = '0;
                    w_cy_n = r_cy + 1'b1;
                end else begin
                    w_cx_n = r_cx + 1'b1;
                end
            end
            default: w_st_n = IDLE;
        endcase
    end

    // Origin and colour of the pixel about to be registered; on acceptance the
    // latched command is not yet visible, so take it straight from the inputs.
    always_comb begin
        if (w_st_n == ERASE) begin
            w_ox  = r_prev_x;
            w_oy  = r_prev_y;
            w_col = BG;
        end else if (w_accept) begin
            w_ox  = x_in;
            w_oy  = y_in;
            w_col = colour_in;
        end else begin
            w_ox  = r_lx;
            w_oy  = r_ly;
            w_col = r_lc;
        end
        w_sx = {1'b0, w_ox} + (XW+1)'(w_cx_n);
        w_sy = {1'b0, w_oy} + (YW+1)'(w_cy_n);
        w_on = (w_st_n == ERASE) || (w_st_n == DRAW);
        w_in = (w_sx < SW) && (w_sy < SH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_st         <= IDLE;
            r_cx         <= '0;
            r_cy         <= '0;
            r_lx         <= '0;
            r_ly         <= '0;
            r_lc         <= '0;
            r_eo         <= 1'b0;
            r_prev_x     <= '0;
            r_prev_y     <= '0;
            r_prev_valid <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_col        <= '0;
            r_plot       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_st <= w_st_n;
            r_cx <= w_cx_n;
            r_cy <= w_cy_n;
            if (w_accept) begin
                r_lx <= x_in;
                r_ly <= y_in;
                r_lc <= colour_in;
                r_eo <= erase_only;
            end
            if (r_st == DRAW && w_last) begin
                r_prev_x     <= r_lx;
                r_prev_y     <= r_ly;
                r_prev_valid <= 1'b1;
            end else if (r_st == ERASE && w_last && r_eo) begin
                r_prev_valid <= 1'b0;
            end
            r_plot <= w_on && w_in;
            r_busy <= w_on;
            r_done <= (w_st_n == DONE);
            if (w_on) begin
                r_x   <= w_sx[XW-1:0];
                r_y   <= w_sy[YW-1:0];
                r_col <= w_col;
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_col;
    assign plot   = r_plot;

endmodule

// File: tb/tb_sprite_rect_draw.sv
// Scoreboard bench: two plotters (erase enabled / disabled) share stimulus; a
// rectangle model predicts every plotted pixel and done pulse with its cycle.
module tb_sprite_rect_draw;

    localparam int W = 4, H = 4, SCW = 160, SCH = 120;

    typedef struct {
        int cyc;
        bit dn;
        int x;
        int y;
        int c;
    } exp_t;

    logic clk = 1'b0;
    logic resetn, go, eo;
    logic [7:0] xi;
    logic [6:0] yi;
    logic [2:0] ci;
    logic b0, d0, p0, b1, d1, p1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] c0, c1;

    exp_t q0[$], q1[$];
    int total = 0, bad = 0, cyc = 0;
    int acc[2], len[2], rdy[2], px[2], py[2];
    bit pv[2];

    sprite_rect_draw u0 (
        .clk(clk), .resetn(resetn), .go(go), .erase_only(eo), .x_in(xi), .y_in(yi),
        .colour_in(ci), .busy(b0), .done(d0), .x(x0), .y(y0), .colour(c0), .plot(p0));

    sprite_rect_draw #(.ERASE_EN(0)) u1 (
        .clk(clk), .resetn(resetn), .go(go), .erase_only(eo), .x_in(xi), .y_in(yi),
        .colour_in(ci), .busy(b1), .done(d1), .x(x1), .y(y1), .colour(c1), .plot(p1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            acc[d] = -1; len[d] = 0; rdy[d] = 0; pv[d] = 0; px[d] = 0; py[d] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    // One rectangle pass in row-major order; every pixel costs a cycle, only
    // on-screen ones are expected on the plot stream.
    task automatic add_pass(input int d, input int ox, input int oy, input int col, inout int n);
        exp_t e;
        for (int j = 0; j < H; j++)
            for (int i = 0; i < W; i++) begin
                if (ox + i < SCW && oy + j < SCH) begin
                    e.cyc = cyc + n; e.dn = 0; e.x = ox + i; e.y = oy + j; e.c = col;
                    push(d, e);
                end
                n++;
            end
    endtask

    task automatic model_edge();
        exp_t e;
        int n;
        if (!resetn || !go) return;
        for (int d = 0; d < 2; d++) begin
            if (cyc >= rdy[d]) begin
                n = 0;
                if ((d == 0 || eo) && pv[d]) add_pass(d, px[d], py[d], 0, n);
                if (!eo) add_pass(d, int'(xi), int'(yi), int'(ci), n);
                e.cyc = cyc + n; e.dn = 1; e.x = 0; e.y = 0; e.c = 0;
                push(d, e);
                if (!eo) begin
                    pv[d] = 1; px[d] = int'(xi); py[d] = int'(yi);
                end else begin
                    pv[d] = 0;
                end
                acc[d] = cyc; len[d] = n; rdy[d] = cyc + n + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic cmd(input bit e, input int xv, input int yv, input int cv);
        go = 1'b1; eo = e; xi = 8'(xv); yi = 7'(yv); ci = 3'(cv);
        tick();
        go = 1'b0; eo = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (cyc < rdy[0] || cyc < rdy[1]); i++) tick();
        if (cyc < rdy[0] || cyc < rdy[1]) chk("idle_timeout", cyc, rdy[0] > rdy[1] ? rdy[0] : rdy[1]);
        tick();
    endtask

    task automatic mon(input int d, input bit p, input bit dn, input bit b,
                       input int xv, input int yv, input int cv);
        exp_t e;
        bit have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        chk($sformatf("busy%0d", d), int'(b),
            int'(acc[d] >= 0 && cyc >= acc[d] && cyc < acc[d] + len[d]));
        if (p || dn) begin
            if (!have) begin
                chk($sformatf("unexpected_out%0d", d), int'(p || dn), 0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk($sformatf("out_cyc%0d", d), cyc, e.cyc);
                chk($sformatf("out_done%0d", d), int'(dn), int'(e.dn));
                if (!e.dn) begin
                    chk($sformatf("pix_x%0d", d), xv, e.x);
                    chk($sformatf("pix_y%0d", d), yv, e.y);
                    chk($sformatf("pix_c%0d", d), cv, e.c);
                end
            end
        end else if (have) begin
            e = (d == 0) ? q0[0] : q1[0];
            if (e.cyc <= cyc) begin
                chk($sformatf("missed_out%0d_exp_cyc%0d", d, e.cyc), int'(p || dn), 1);
                if (d == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            mon(0, p0, d0, b0, int'(x0), int'(y0), int'(c0));
            mon(1, p1, d1, b1, int'(x1), int'(y1), int'(c1));
        end
    end

    task automatic chk_quiet(input string tag);
        chk({tag, "_plot0"}, int'(p0), 0); chk({tag, "_busy0"}, int'(b0), 0);
        chk({tag, "_done0"}, int'(d0), 0); chk({tag, "_plot1"}, int'(p1), 0);
        chk({tag, "_busy1"}, int'(b1), 0); chk({tag, "_done1"}, int'(d1), 0);
    endtask

    initial begin
        resetn = 1'b1; go = 1'b0; eo = 1'b0; xi = '0; yi = '0; ci = '0;
        model_reset();
        #2 resetn = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset_x0", int'(x0), 0); chk("reset_y0", int'(y0), 0); chk("reset_c0", int'(c0), 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // Plain draw, then a one-pixel move (erase + draw on u0).
        cmd(0, 10, 20, 4);
        wait_idle();
        cmd(0, 11, 20, 4);
        wait_idle();

        // Bottom-right clipping.
        cmd(0, 158, 118, 5);
        wait_idle();

        // go held high: ignored while busy, accepted again in the done cycle.
        go = 1'b1;
        for (int i = 0; i < 80; i++) begin
            xi = 8'($urandom_range(0, 200)); yi = 7'($urandom_range(0, 127));
            ci = 3'($urandom_range(0, 7));
            tick();
        end
        go = 1'b0;
        wait_idle();

        // Erase-only twice: second has nothing to erase.
        cmd(1, 0, 0, 0);
        wait_idle();
        cmd(1, 0, 0, 0);
        wait_idle();

        // Reset during the fifth draw pixel, then a fresh draw without erase.
        cmd(0, 30, 40, 6);
        repeat (4) tick();
        resetn = 1'b0;
        #1;
        chk_quiet("midreset");
        model_reset();
        tick(); tick();
        resetn = 1'b1;
        tick();
        cmd(0, 50, 60, 2);
        wait_idle();

        // Random commands, some overlapping busy periods.
        for (int n = 0; n < 40; n++) begin
            int hold = $urandom_range(1, 3);
            go = 1'b1;
            eo = ($urandom_range(0, 4) == 0);
            xi = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 159));
            yi = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 119));
            ci = 3'($urandom_range(0, 7));
            repeat (hold) tick();
            go = 1'b0; eo = 1'b0;
            repeat ($urandom_range(0, 20)) tick();
        end
        wait_idle();
        tick(); tick();

        chk("leftover0", q0.size(), 0);
        chk("leftover1", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_rect_draw.md
Name: sprite_rect_draw

Overview:
- Parametrised rectangle sprite plotter. It is the generalised successor of the fixed-size ball drawer.
- On a go command it erases the sprite's previous rectangle to the background colour, then draws the new rectangle. It emits one pixel per clock on an x/y/colour/plot stream for the VGA adapter write port.
- Supports any sprite size, screen clipping and an erase-only mode, so one block serves ball, paddle and bricks.

Parameters:
- XW, 8, x coordinate width
- YW, 7, y coordinate width
- CW, 3, colour width
- SPR_W, 4, sprite width in pixels (>=1)
- SPR_H, 4, sprite height in pixels (>=1)
- SCREEN_W, 160, visible width; x >= SCREEN_W is clipped
- SCREEN_H, 120, visible height; y >= SCREEN_H is clipped
- BG_COLOUR, 0, colour used for erase
- ERASE_EN, 1, 1 = erase previous rectangle before each draw; 0 = never erase

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- go  in  1  command strobe, accepted only when busy=0
- erase_only  in  1  sampled with go; 1 = erase previous rectangle, no draw
- x_in  in  XW  top-left x of new sprite
- y_in  in  YW  top-left y of new sprite
- colour_in  in  CW  sprite colour
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- x  out  XW  pixel x
- y  out  YW  pixel y
- colour  out  CW  pixel colour
- plot  out  1  pixel write enable

Behaviour:
- Reset, asynchronous, active-low:
  - state=IDLE
  - busy, done, plot, x, y, colour all 0
  - prev_valid=0; prev_x, prev_y = 0
- Reset mid-operation aborts immediately. There is no partial completion and no done pulse.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - go=1 at edge k latches x_in, y_in, colour_in and erase_only.
  - Next state:
    - ERASE if (ERASE_EN or erase_only) and prev_valid
    - else DONE if erase_only
    - else DRAW
  - Scan counters cx=0, cy=0.
- ERASE and DRAW scan one pixel per cycle:
  - Row-major order, cx fastest.
  - cx in 0..SPR_W-1, cy in 0..SPR_H-1.
  - Origin is prev_x/prev_y for ERASE and the latched x/y for DRAW.
- Outputs are registered. The pixel for a counter value appears the cycle after that value is formed.
  - First pixel of a command is presented in the cycle after edge k.
- Pixel coordinate sums are computed one bit wider than XW/YW.
  - plot=1 only if sum_x < SCREEN_W and sum_y < SCREEN_H.
  - Clipped pixels still consume their cycle, with plot=0. x/y output are the truncated sums.
  - There is no wrap to the screen's left or top.
- colour output: BG_COLOUR during ERASE, latched colour during DRAW.
- After the last ERASE pixel:
  - If erase_only: go to DONE, set prev_valid=0.
  - Else: go to DRAW.
- After the last DRAW pixel: go to DONE, prev_x/prev_y = latched x/y, prev_valid=1.
- DONE lasts one cycle with done=1, busy=0, plot=0, then IDLE.
  - go is accepted in DONE and in IDLE.
- busy=1 from the cycle after acceptance through the last pixel cycle.
- go while busy=1 is ignored, not queued.
- Total cycles from acceptance to done = E + D + 1, where:
  - E = SPR_W*SPR_H if an erase pass runs, else 0
  - D = SPR_W*SPR_H if a draw pass runs, else 0
- x_in/y_in/colour_in changes after acceptance have no effect.
- Between pixels plot=0. x, y and colour hold their last values.

Test Plan:
- Defaults, reset, then go with x_in=10, y_in=20, colour_in=4 → 16 plots with colour 4 at (10,20),(11,20)...(13,23) in row-major order, on cycles k+1..k+16; done=1 on k+17; no erase pixels.
- Then go with x_in=11, y_in=20, colour_in=4 → 16 colour-0 plots over (10..13, 20..23), then 16 colour-4 plots over (11..14, 20..23); done on cycle k+33.
- Clipping: after a sprite is drawn at (158,118) with ERASE_EN=0 → 16 pixel cycles with plot=1 only at (158,118),(159,118),(158,119),(159,119); done on k+17.
- Assert go every cycle during a draw → busy stays 1, no new command starts mid-scan; a go held through the DONE cycle starts the next command immediately.
- erase_only=1 with prev_valid=1 → 16 colour-0 plots at the previous rectangle, then done. A second erase_only → done on k+1 with zero plots.
- Drop resetn at the 5th DRAW pixel → plot, busy and done go 0 asynchronously. The next go (prev_valid=0) draws with no erase pass.
